// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding and the reset/sequential PC values.
package if_fetch_unit_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_DROP = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          PC_STEP  = 4;

endpackage

// File: rtl/if_fetch_unit_queue.sv
// Two-entry synchronous FIFO with flush and occupancy count.
// Head entry is presented combinationally on rdata_o.
module fetch_queue #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A push into a full queue is legal only while the head leaves.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake,
// redirect handling and a 2-entry buffer towards decode.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(if_fetch_unit_pkg::RESET_PC),
  parameter int PC_STEP = if_fetch_unit_pkg::PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready
);

  localparam int QW = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;

  logic          req_raw, ack;
  logic          q_flush, q_push, q_pop, q_valid;
  logic [QW-1:0] q_rdata;
  logic [1:0]    q_count;

  fetch_queue #(.W(QW)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (q_flush),
    .push_i  (q_push),
    .wdata_i ({pc_q, imem_rdata}),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .valid_o (q_valid),
    .count_o (q_count)
  );

  // Request only when the returning word is sure to find a free slot.
  assign req_raw = (state_q == S_DROP) || (q_count != 2'd2);
  assign ack     = imem_ack && req_raw;
  assign q_pop   = q_valid && out_ready;

  assign imem_req  = !rst && req_raw;
  assign imem_addr = rst ? '0 :
                     (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign out_valid = !rst && q_valid;
  assign out_pc    = rst ? '0 : q_rdata[QW-1:DATA_W];
  assign out_instr = rst ? '0 : q_rdata[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    q_flush     = 1'b0;
    q_push      = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          q_flush = 1'b1;
          if (req_raw && !ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (ack) begin
          q_push = 1'b1;
          pc_d   = pc_q + ADDR_W'(PC_STEP);
        end
      end
      S_DROP: begin
        q_flush = redirect_valid;
        if (redirect_valid) pc_d = redirect_pc;
        if (ack) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

endmodule
